// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative MULT/MULTU/DIV/DIVU sequencer that owns the HI/LO
// registers. A single 64-bit accumulator is shared by both datapaths. For a
// multiply it holds the {partial product, remaining multiplier} pair. For a
// divide it holds the {partial remainder, dividend/quotient} pair.
module muldiv_seq #(
    parameter int ITER = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] x,
    input  logic [31:0] y,
    input  logic        wr_hi,
    input  logic        wr_lo,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        div0,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int CW = $clog2(ITER + 1);

    typedef enum logic [1:0] {S_IDLE, S_PREP, S_RUN, S_FIX} state_t;

    state_t        state_q, state_d;
    logic [1:0]    op_q, op_d;
    logic [31:0]   x_q, x_d;
    logic [31:0]   y_q, y_d;
    logic [63:0]   acc_q, acc_d;
    logic [31:0]   mag_q, mag_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          neg_lo_q, neg_lo_d;   // negate product / quotient
    logic          neg_hi_q, neg_hi_d;   // negate remainder
    logic          dz_q, dz_d;           // divide by zero seen in PREP
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          div0_q, div0_d;
    logic [31:0]   hi_q, hi_d;
    logic [31:0]   lo_q, lo_d;

    // op[0] = 1 marks the unsigned variants, op[1] = 1 marks divides
    logic        is_signed;
    logic        is_div;
    logic [31:0] x_abs;
    logic [31:0] y_abs;
    logic [32:0] mul_sum;
    logic [33:0] div_trial;
    logic [63:0] prod_fix;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    assign is_signed = ~op_q[0];
    assign is_div    = op_q[1];
    // The magnitude of 0x80000000 is 2^31. It is still representable unsigned.
    assign x_abs     = (is_signed && x_q[31]) ? -x_q : x_q;
    assign y_abs     = (is_signed && y_q[31]) ? -y_q : y_q;

    // Shift-add step: add the multiplicand into the upper half when the
    // multiplier LSB is set. The carry then shifts in as the new MSB.
    assign mul_sum   = {1'b0, acc_q[63:32]} + {1'b0, (acc_q[0] ? mag_q : 32'd0)};

    // Restoring step: trial-subtract the divisor from {remainder, next dividend bit}
    assign div_trial = {1'b0, acc_q[63:31]} - {2'b00, mag_q};

    assign prod_fix  = neg_lo_q ? -acc_q : acc_q;
    assign quo_fix   = neg_lo_q ? -acc_q[31:0] : acc_q[31:0];
    assign rem_fix   = neg_hi_q ? -acc_q[63:32] : acc_q[63:32];

    // Next-state and datapath logic for the IDLE/PREP/RUN/FIX sequence
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        x_d      = x_q;
        y_d      = y_q;
        acc_d    = acc_q;
        mag_d    = mag_q;
        cnt_d    = cnt_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        dz_d     = dz_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        div0_d   = 1'b0;
        hi_d     = hi_q;
        lo_d     = lo_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    // start wins over a same-cycle MTHI/MTLO
                    op_d    = op;
                    x_d     = x;
                    y_d     = y;
                    busy_d  = 1'b1;
                    state_d = S_PREP;
                end else begin
                    if (wr_hi) hi_d = wdata;
                    if (wr_lo) lo_d = wdata;
                end
            end
            S_PREP: begin
                neg_lo_d = is_signed & (x_q[31] ^ y_q[31]);
                neg_hi_d = is_signed & x_q[31];
                dz_d     = is_div && (y_q == 32'd0);
                cnt_d    = '0;
                acc_d    = is_div ? {32'd0, x_abs} : {32'd0, y_abs};
                mag_d    = is_div ? y_abs : x_abs;
                state_d  = S_RUN;
            end
            S_RUN: begin
                if (is_div) begin
                    if (!div_trial[33]) acc_d = {div_trial[31:0], acc_q[30:0], 1'b1};
                    else                acc_d = {acc_q[62:0], 1'b0};
                end else begin
                    acc_d = {mul_sum, acc_q[31:1]};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(ITER - 1)) state_d = S_FIX;
            end
            S_FIX: begin
                // A divide by zero keeps the old HI/LO contents
                if (!dz_q) begin
                    if (is_div) begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end else begin
                        hi_d = prod_fix[63:32];
                        lo_d = prod_fix[31:0];
                    end
                end
                done_d  = 1'b1;
                div0_d  = dz_q;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            op_q     <= 2'b00;
            x_q      <= 32'd0;
            y_q      <= 32'd0;
            acc_q    <= 64'd0;
            mag_q    <= 32'd0;
            cnt_q    <= '0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            dz_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            div0_q   <= 1'b0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            x_q      <= x_d;
            y_q      <= y_d;
            acc_q    <= acc_d;
            mag_q    <= mag_d;
            cnt_q    <= cnt_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            dz_q     <= dz_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            div0_q   <= div0_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign div0 = div0_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed testbench for muldiv_seq: fixed vectors with hand-computed HI/LO,
// latency, done/div0 pulse and MTHI/MTLO/reset interaction checks.
module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] x;
    logic [31:0] y;
    logic        wr_hi;
    logic        wr_lo;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        div0;
    logic [31:0] hi;
    logic [31:0] lo;

    localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;

    muldiv_seq #(.ITER(32)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .x     (x),
        .y     (y),
        .wr_hi (wr_hi),
        .wr_lo (wr_lo),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .div0  (div0),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Observations collected by run_op
    int          busy_cnt;
    int          done_cnt;
    int          done_k;
    int          div0_cnt;
    int          div0_with_done;
    logic        busy_snap;
    logic [31:0] hi_snap, lo_snap;
    logic [31:0] hi_mid, lo_mid;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Issue one operation and watch 60 cycles after the accept edge.
    // disturb: 0 none, 1 start+wr_hi at cycle 10, 2 reset at cycle 20.
    // Sample index k = negedge following accept edge E0 + k.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int disturb, input logic with_wr_lo);
        @(negedge clk);
        start = 1'b1; op = o; x = a; y = b;
        wr_lo = with_wr_lo; wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        start = 1'b0; wr_lo = 1'b0;
        x = ~a; y = a ^ b;
        busy_cnt = 0; done_cnt = 0; done_k = -1; div0_cnt = 0; div0_with_done = 0;
        busy_snap = 1'b1; hi_snap = 32'hx; lo_snap = 32'hx; hi_mid = 32'hx; lo_mid = 32'hx;
        for (int k = 0; k < 60; k++) begin
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_k < 0) done_k = k;
            end
            if (div0) div0_cnt++;
            if (div0 && done) div0_with_done++;
            if (k == 20) begin hi_mid = hi; lo_mid = lo; end
            if (k == 21) begin busy_snap = busy; hi_snap = hi; lo_snap = lo; end
            if (disturb == 1 && k == 10) begin
                start = 1'b1; wr_hi = 1'b1; wdata = 32'h5555_5555; x = 32'h1; y = 32'h1;
            end else if (disturb == 2 && k == 20) begin
                reset = 1'b1;
            end else begin
                start = 1'b0; wr_hi = 1'b0; reset = 1'b0;
            end
            @(negedge clk);
        end
        $display("op=%0d x=%h y=%h -> hi=%h lo=%h busy_cycles=%0d done_at=%0d div0s=%0d",
                 o, a, b, hi, lo, busy_cnt, done_k, div0_cnt);
    endtask

    task automatic check_result(input string tag, input logic [31:0] eh, input logic [31:0] el,
                                input int ed0);
        chk({tag, ".hi"}, 64'(hi), 64'(eh));
        chk({tag, ".lo"}, 64'(lo), 64'(el));
        chk({tag, ".busy_cycles"}, 64'(busy_cnt), 64'd34);
        chk({tag, ".done_at"}, 64'(done_k), 64'd34);
        chk({tag, ".done_pulses"}, 64'(done_cnt), 64'd1);
        chk({tag, ".div0_pulses"}, 64'(div0_cnt), 64'(ed0));
        chk({tag, ".div0_with_done"}, 64'(div0_with_done), 64'(ed0));
    endtask

    task automatic mt(input logic h, input logic l, input logic [31:0] d);
        @(negedge clk);
        wr_hi = h; wr_lo = l; wdata = d;
        @(negedge clk);
        wr_hi = 1'b0; wr_lo = 1'b0;
        $display("mt wr_hi=%0b wr_lo=%0b data=%h -> hi=%h lo=%h", h, l, d, hi, lo);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = 2'b00; x = 32'd0; y = 32'd0;
        wr_hi = 1'b0; wr_lo = 1'b0; wdata = 32'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("reset.busy", 64'(busy), 64'd0);
        chk("reset.done", 64'(done), 64'd0);
        chk("reset.div0", 64'(div0), 64'd0);
        chk("reset.hi", 64'(hi), 64'd0);
        chk("reset.lo", 64'(lo), 64'd0);

        // -3 * 5 = -15
        run_op(OP_MULT, 32'hFFFF_FFFD, 32'd5, 0, 1'b0);
        check_result("mult_neg", 32'hFFFF_FFFF, 32'hFFFF_FFF1, 0);

        // (2^32-1)^2 = 0xFFFFFFFE_00000001
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
        check_result("multu_max", 32'hFFFF_FFFE, 32'h0000_0001, 0);
        chk("multu_max.hi_mid", 64'(hi_mid), 64'hFFFF_FFFF);

        // -7 / 2 = -3 rem -1
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 0, 1'b0);
        check_result("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);

        // 7 / -2 = -3 rem 1
        run_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, 0, 1'b0);
        check_result("div_negy", 32'h0000_0001, 32'hFFFF_FFFD, 0);

        // MTHI/MTLO: both in one cycle, then separately
        mt(1'b1, 1'b1, 32'h0000_00AB);
        chk("mt_both.hi", 64'(hi), 64'h0000_00AB);
        chk("mt_both.lo", 64'(lo), 64'h0000_00AB);
        mt(1'b1, 1'b0, 32'h0000_0011);
        mt(1'b0, 1'b1, 32'h0000_0022);
        chk("mt_sep.hi", 64'(hi), 64'h0000_0011);
        chk("mt_sep.lo", 64'(lo), 64'h0000_0022);

        // Divide by zero leaves HI/LO untouched
        run_op(OP_DIVU, 32'd7, 32'd0, 0, 1'b0);
        check_result("divu_zero", 32'h0000_0011, 32'h0000_0022, 1);

        // Overflow case with a stray start and MTHI during RUN
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1, 1'b0);
        check_result("div_ovf", 32'h0000_0000, 32'h8000_0000, 0);

        // start with wr_lo in the same cycle: write dropped
        run_op(OP_MULTU, 32'h0001_0000, 32'h0003_0000, 0, 1'b1);
        chk("start_wrlo.lo_mid", 64'(lo_mid), 64'h8000_0000);
        check_result("start_wrlo", 32'h0000_0003, 32'h0000_0000, 0);

        // Reset during RUN discards the operation
        run_op(OP_MULT, 32'd6, 32'd7, 2, 1'b0);
        chk("rst_mid.hi_mid", 64'(hi_mid), 64'h0000_0003);
        chk("rst_mid.busy", 64'(busy_snap), 64'd0);
        chk("rst_mid.hi", 64'(hi_snap), 64'd0);
        chk("rst_mid.lo", 64'(lo_snap), 64'd0);
        chk("rst_mid.done_pulses", 64'(done_cnt), 64'd0);

        // Fresh operation after reset: -2 * -3 = 6
        run_op(OP_MULT, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 0, 1'b0);
        check_result("after_rst", 32'h0000_0000, 32'h0000_0006, 0);

        // -7 / -2 = 3 rem -1
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 0, 1'b0);
        check_result("div_both_neg", 32'hFFFF_FFFF, 32'h0000_0003, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Iterative multiply/divide sequencer for the MIPS pipeline, handling MULT, MULTU, DIV and DIVU outside the single-cycle ALU. It accepts one operation at a time from the EX stage and runs a 32-iteration shift-add or restoring-divide datapath. It owns the architectural HI/LO registers and raises `busy` so the hazard unit can stall HI/LO consumers and new mul/div issues.

## Interface

Parameters:
- `ITER`, 32, iterations per operation; fixed by the 32-bit operand width.

Ports:
- `clk` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high; clears all state.
- `start` in 1: single-cycle request; honoured only in IDLE.
- `op` in 2: operation code: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `x` in 32: rs operand (multiplicand / dividend).
- `y` in 32: rt operand (multiplier / divisor).
- `wr_hi` in 1: MTHI write strobe.
- `wr_lo` in 1: MTLO write strobe.
- `wdata` in 32: MTHI/MTLO data.
- `busy` out 1: registered; high from the cycle after an accepted `start` through the FIX cycle.
- `done` out 1: one-cycle pulse after HI/LO update.
- `div0` out 1: one-cycle pulse coincident with `done` when DIV/DIVU had `y == 0`.
- `hi` out 32: HI register.
- `lo` out 32: LO register.

## Operation

- Reset: IDLE state. `busy`, `done` and `div0` are 0. `hi` and `lo` are 0. Iteration counter is 0.
- States and transitions:
  - IDLE: `start` latches `op`, `x`, `y`, then goes to PREP.
  - PREP: for signed ops, takes absolute values and records the result signs. Clears the accumulator and counter. Sets the divide-by-zero flag if DIV/DIVU and `y == 0`. Goes to RUN.
  - RUN: one iteration per cycle; goes to FIX after iteration 32.
  - FIX: applies sign correction and writes `hi`/`lo`. Pulses `done` and, if applicable, `div0`. Goes to IDLE.
- Multiply: 64-bit unsigned shift-add on magnitudes. If the signs differ, the result is negated as 64-bit two's complement. `hi`:`lo` = 64-bit product.
- Divide: restoring division on magnitudes. Quotient truncates toward zero and goes to `lo`. The remainder takes the sign of the dividend and goes to `hi`.
  - 0x80000000 / -1 (DIV): `lo` = 0x80000000, `hi` = 0. Results wrap; no trap.
- Divide by zero: full latency is kept. `hi`/`lo` are left unchanged and `div0` pulses with `done`.
- MTHI/MTLO:
  - In IDLE with `start` low, `wr_hi`/`wr_lo` load `wdata` at the edge; both may write in the same cycle.
  - Writes are dropped when `busy` is high or when `start` is high in the same cycle, because `start` has priority.
- A `start` while not in IDLE is ignored with no queueing. The hazard unit guarantees this does not happen; the block must still tolerate it.
- Operands are latched at the accept edge. Later changes on `x`/`y` have no effect.
- A `reset` asserted in any state returns the block to IDLE with all reset values at the next edge. The in-flight result is discarded.

## Timing

- Edge E0: `start` sampled in IDLE, and `busy` becomes 1 after E0.
- E1: PREP.
- E2 through E33: 32 RUN iterations.
- E34: FIX. `hi`/`lo` update, `busy` returns to 0, and `done` is high for the following cycle only.
- Total: `busy` is high for 34 cycles. The result is readable in the cycle after E34.
- A new `start` may be sampled at E35, which is the first IDLE edge with `busy` = 0.
- `hi`/`lo` hold their old values throughout RUN; no partial results are visible.
- All outputs are registered, with no combinational path from inputs to outputs.

## Test plan

- MULT x=0xFFFFFFFD (-3), y=5 -> after 34 busy cycles, `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1, `done` pulses once, `div0`=0.
- MULTU x=0xFFFFFFFF, y=0xFFFFFFFF -> `hi`=0xFFFFFFFE, `lo`=0x00000001. Then DIV x=0xFFFFFFF9 (-7), y=2 -> `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
- Preload `hi`=0x11, `lo`=0x22 via MTHI/MTLO in IDLE, then DIVU x=7, y=0 -> `div0` and `done` pulse together at cycle 35, `hi`=0x11 and `lo`=0x22 unchanged.
- DIV x=0x80000000, y=0xFFFFFFFF -> `lo`=0x80000000, `hi`=0. A second `start` and `wr_hi` at cycle 10 of the run are both ignored; the result and latency are unchanged.
- `start` and `wr_lo` asserted in the same IDLE cycle -> the operation is accepted, the `lo` write is dropped, and the final `lo` is the operation result.
- `reset` pulsed at cycle 20 of a MULT -> next cycle `busy`=0, `hi`=`lo`=0, no `done`. A fresh `start` is then accepted normally.
